slave_port: RTL and testbench

SLAVE_PORT -- requirements
Module: slave_port

---
 rtl/slave_port_if.sv | 31 +++
 rtl/slave_port.sv | 174 +++++++++++++++++
 tb/tb_slave_port.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/slave_port_if.sv
// Serial frame bus plus local memory port bundle for slave_port.
// master drives the frame and returns memory data; slave is the port itself.
interface slave_port_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
);
   logic                  swdata;
   logic                  smode;
   logic                  mvalid;
   logic                  srdata;
   logic                  svalid;
   logic                  sready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_wen;
   logic                  mem_ren;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_rvalid;

   modport master (
      output swdata, smode, mvalid, mem_rdata, mem_rvalid,
      input  srdata, svalid, sready, mem_addr, mem_wdata,
      input  mem_wen, mem_ren
   );

   modport slave (
      input  swdata, smode, mvalid, mem_rdata, mem_rvalid,
      output srdata, svalid, sready, mem_addr, mem_wdata,
      output mem_wen, mem_ren
   );
endinterface

// File: rtl/slave_port.sv
// Serial-to-memory slave port: LSB-first address/data frames, serial read-back.
// Define SLAVE_PORT_WR_ACK_EN to add a one-cycle write acknowledge (WR_ACK).
module slave_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   slave_port_if.slave bus
);
   localparam int MW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW = $clog2(MW + 1);
   localparam logic [CW-1:0] LAST_A = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0] LAST_D = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, WDATA, MEM_WR, MEM_RD, WAIT_RD, RD_TX
`ifdef SLAVE_PORT_WR_ACK_EN
      , WR_ACK
`endif
   } state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic                  mode;
   logic [ADDR_WIDTH-1:0] addr_sr;
   logic [DATA_WIDTH-1:0] data_sr;
   logic [DATA_WIDTH-1:0] rd_sr;
   logic [ADDR_WIDTH-1:0] addr_nx;
   logic [DATA_WIDTH-1:0] data_nx;
   logic [DATA_WIDTH-1:0] rd_nx;

   // Right-shift in at the MSB: after a full field the first bit sits at bit 0.
   always_comb begin
      addr_nx = (addr_sr >> 1) |
                (ADDR_WIDTH'(bus.swdata) << (ADDR_WIDTH - 1));
      data_nx = (data_sr >> 1) |
                (DATA_WIDTH'(bus.swdata) << (DATA_WIDTH - 1));
      rd_nx   = rd_sr >> 1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         mode          <= 1'b0;
         addr_sr       <= '0;
         data_sr       <= '0;
         rd_sr         <= '0;
         bus.srdata    <= 1'b0;
         bus.svalid    <= 1'b0;
         bus.sready    <= 1'b1;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wen   <= 1'b0;
         bus.mem_ren   <= 1'b0;
      end else begin
         bus.mem_wen <= 1'b0;
         bus.mem_ren <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.mvalid) begin
                  mode       <= bus.smode;
                  addr_sr    <= addr_nx;
                  bus.sready <= 1'b0;
                  if (ADDR_WIDTH == 1) begin
                     cnt <= '0;
                     if (bus.smode) begin
                        state <= WDATA;
                     end else begin
                        state        <= MEM_RD;
                        bus.mem_addr <= addr_nx;
                        bus.mem_ren  <= 1'b1;
                     end
                  end else begin
                     cnt   <= CW'(1);
                     state <= ADDR;
                  end
               end
            end
            ADDR: begin
               if (!bus.mvalid) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  addr_sr    <= '0;
                  bus.sready <= 1'b1;
               end else begin
                  addr_sr <= addr_nx;
                  if (cnt == LAST_A) begin
                     cnt <= '0;
                     if (mode) begin
                        state <= WDATA;
                     end else begin
                        state        <= MEM_RD;
                        bus.mem_addr <= addr_nx;
                        bus.mem_ren  <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            WDATA: begin
               if (!bus.mvalid) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  addr_sr    <= '0;
                  data_sr    <= '0;
                  bus.sready <= 1'b1;
               end else begin
                  data_sr <= data_nx;
                  if (cnt == LAST_D) begin
                     cnt           <= '0;
                     state         <= MEM_WR;
                     bus.mem_addr  <= addr_sr;
                     bus.mem_wdata <= data_nx;
                     bus.mem_wen   <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            MEM_WR: begin
`ifdef SLAVE_PORT_WR_ACK_EN
               state      <= WR_ACK;
               bus.svalid <= 1'b1;
               bus.srdata <= 1'b1;
`else
               state      <= IDLE;
               bus.sready <= 1'b1;
`endif
            end
`ifdef SLAVE_PORT_WR_ACK_EN
            WR_ACK: begin
               state      <= IDLE;
               bus.svalid <= 1'b0;
               bus.srdata <= 1'b0;
               bus.sready <= 1'b1;
            end
`endif
            MEM_RD: state <= WAIT_RD;
            WAIT_RD: begin
               if (bus.mem_rvalid) begin
                  rd_sr      <= bus.mem_rdata;
                  bus.srdata <= bus.mem_rdata[0];
                  bus.svalid <= 1'b1;
                  cnt        <= '0;
                  state      <= RD_TX;
               end
            end
            RD_TX: begin
               if (cnt == LAST_D) begin
                  cnt        <= '0;
                  bus.svalid <= 1'b0;
                  bus.srdata <= 1'b0;
                  bus.sready <= 1'b1;
                  state      <= IDLE;
               end else begin
                  rd_sr      <= rd_nx;
                  bus.srdata <= rd_nx[0];
                  cnt        <= cnt + CW'(1);
               end
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               bus.svalid <= 1'b0;
               bus.srdata <= 1'b0;
               bus.sready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: write, read, abort, reset and ack cases.
// Optional write acknowledge checked when SLAVE_PORT_WR_ACK_EN is defined.
module tb_slave_port;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;
   int   n_wen;
   int   n_ren;
   int   n_sv;
   int   ren_snap;
   int   wen_snap;

   slave_port_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();

   slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Strobe/valid counters and the srdata-quiet rule, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.mem_wen === 1'b1) n_wen++;
      if (bus.mem_ren === 1'b1) n_ren++;
      if (bus.svalid === 1'b1) n_sv++;
      if (bus.svalid !== 1'b1) chk("srdata_quiet", 32'(bus.srdata), 32'h0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Frame: nab address bits, then 8 data bits for a full write.
   // smode is inverted after the first bit to confirm it is sampled once.
   task automatic frame(input logic m, input logic [11:0] a,
                        input logic [7:0] d, input int nab);
      for (int i = 0; i < nab; i++) begin
         bus.mvalid = 1'b1;
         bus.smode  = (i == 0) ? m : ~m;
         bus.swdata = a[i];
         tick();
      end
      if (m && nab == 12) begin
         for (int i = 0; i < 8; i++) begin
            bus.swdata = d[i];
            tick();
         end
      end
      bus.mvalid = 1'b0;
      bus.swdata = 1'b0;
   endtask

   task automatic after_write(input string tag, input logic [11:0] a,
                              input logic [7:0] d, input int wen_exp);
      chk({tag, "_wen"}, 32'(bus.mem_wen), 32'h1);
      chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(a));
      chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(d));
      chk({tag, "_sv_at_wen"}, 32'(bus.svalid), 32'h0);
      tick();
      chk({tag, "_wen_off"}, 32'(bus.mem_wen), 32'h0);
      chk({tag, "_wen_cnt"}, 32'(n_wen), 32'(wen_exp));
      chk({tag, "_addr_hold"}, 32'(bus.mem_addr), 32'(a));
`ifdef SLAVE_PORT_WR_ACK_EN
      chk({tag, "_ack_sv"}, 32'(bus.svalid), 32'h1);
      chk({tag, "_ack_sd"}, 32'(bus.srdata), 32'h1);
      chk({tag, "_ack_rdy"}, 32'(bus.sready), 32'h0);
      tick();
      chk({tag, "_ack_end"}, 32'(bus.svalid), 32'h0);
`else
      chk({tag, "_no_ack"}, 32'(bus.svalid), 32'h0);
`endif
      chk({tag, "_rdy"}, 32'(bus.sready), 32'h1);
   endtask

   initial begin
      logic [7:0] rd_exp;
      n_chk = 0;
      n_err = 0;
      n_wen = 0;
      n_ren = 0;
      n_sv  = 0;
      rst            = 1'b1;
      bus.swdata     = 1'b0;
      bus.smode      = 1'b0;
      bus.mvalid     = 1'b0;
      bus.mem_rdata  = 8'h00;
      bus.mem_rvalid = 1'b0;
      tick();
      tick();
      chk("rst_sready", 32'(bus.sready), 32'h1);
      chk("rst_svalid", 32'(bus.svalid), 32'h0);
      chk("rst_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
      chk("rst_wen", 32'(bus.mem_wen), 32'h0);
      chk("rst_ren", 32'(bus.mem_ren), 32'h0);
      rst = 1'b0;
      tick();

      frame(1'b1, 12'h0A5, 8'h3C, 12);
      after_write("wr1", 12'h0A5, 8'h3C, 1);
      chk("wr1_no_ren", 32'(n_ren), 32'h0);

      frame(1'b0, 12'h0A5, 8'h00, 12);
      chk("rd_ren", 32'(bus.mem_ren), 32'h1);
      chk("rd_addr", 32'(bus.mem_addr), 32'h0A5);
      bus.mvalid = 1'b1;
      bus.swdata = 1'b1;
      tick();
      chk("rd_ren_off", 32'(bus.mem_ren), 32'h0);
      chk("rd_wait_rdy", 32'(bus.sready), 32'h0);
      tick();
      tick();
      chk("rd_wait_sv", 32'(bus.svalid), 32'h0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 8'h3C;
      n_sv = 0;
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 8'hA5;
      rd_exp = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("rd_sv%0d", i), 32'(bus.svalid), 32'h1);
         chk($sformatf("rd_bit%0d", i), 32'(bus.srdata), 32'(rd_exp[i]));
         bus.swdata = ~bus.swdata;
         tick();
      end
      bus.mvalid = 1'b0;
      chk("rd_sv_end", 32'(bus.svalid), 32'h0);
      chk("rd_rdy_end", 32'(bus.sready), 32'h1);
      chk("rd_sv_cnt", 32'(n_sv), 32'h8);
      chk("rd_ren_cnt", 32'(n_ren), 32'h1);
      chk("rd_no_wen", 32'(n_wen), 32'h1);

      frame(1'b1, 12'h0A5, 8'h00, 7);
      tick();
      chk("abort_rdy", 32'(bus.sready), 32'h1);
      chk("abort_wen", 32'(n_wen), 32'h1);
      chk("abort_ren", 32'(n_ren), 32'h1);
      frame(1'b1, 12'h001, 8'hFF, 12);
      after_write("wr2", 12'h001, 8'hFF, 2);

      frame(1'b0, 12'h123, 8'h00, 12);
      tick();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 8'hFF;
      tick();
      bus.mem_rvalid = 1'b0;
      tick();
      tick();
      tick();
      chk("rst_tx_sv", 32'(bus.svalid), 32'h1);
      chk("rst_tx_bit3", 32'(bus.srdata), 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_async_sv", 32'(bus.svalid), 32'h0);
      chk("rst_async_sd", 32'(bus.srdata), 32'h0);
      chk("rst_async_rdy", 32'(bus.sready), 32'h1);
      chk("rst_async_addr", 32'(bus.mem_addr), 32'h0);
      tick();
      rst = 1'b0;
      n_sv = 0;
      ren_snap = n_ren;
      wen_snap = n_wen;
      repeat (12) tick();
      chk("post_rst_sv", 32'(n_sv), 32'h0);
      chk("post_rst_ren", 32'(n_ren), 32'(ren_snap));
      chk("post_rst_wen", 32'(n_wen), 32'(wen_snap));

      frame(1'b1, 12'hFFF, 8'h00, 12);
      after_write("wr3", 12'hFFF, 8'h00, wen_snap + 1);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
